dot_frame_source: RTL and testbench
===================================

// Module: dot_frame_source
// PURPOSE
//  Column data source for the 16x16 dot-matrix display driver.
//  - Holds a double-buffered 16x16 frame: host writes the back buffer, display reads the front buffer.
//  - Tracks the driver's column index column_seg and answers each new index with in_column plus a one-cycle LOAD strobe.
//  - Swaps buffers only at a frame boundary (column_seg wraps 15->0) so the frame never tears.
// PARAMETERS
//  COLS   16  columns per frame; power of 2; also the depth of each buffer
//  AW     4   column index width, log2(COLS)
//  DW     16  rows per column; width of in_column / wr_data
// PORTS
//  CLK         in   1   system clock, rising edge
//  RESET       in   1   asynchronous, active-high reset
//  wr_en       in   1   host write strobe into the back buffer
//  wr_addr     in   AW  column written
//  wr_data     in   DW  column bit pattern, bit n = row n
//  swap_req    in   1   pulse: request a front/back swap at the next frame boundary
//  clr_req     in   1   pulse: zero the entire back buffer
//  column_seg  in   AW  column index currently selected by the display driver
//  in_column   out  DW  column data presented to the driver
//  LOAD        out  1   one-cycle strobe: in_column is valid for column_seg
//  IN_CLR      out  1   one-cycle display clear, issued on swap execution
//  swap_pend   out  1   high from swap_req until the swap executes
//  busy        out  1   high while a back-buffer clear is running
// BEHAVIOUR
//  Reset: both buffers zero, front = buffer 0, in_column = 0, LOAD = 0, IN_CLR = 0, swap_pend = 0, busy = 0.
//  - The column_seg shadow register resets to all-ones, so the first index 0 after reset counts as a change.
//  Column change:
//  - Cycle t: column_seg differs from its shadow register.
//  - t+1: shadow updates; front[column_seg] is latched into in_column.
//  - t+1: LOAD is high for exactly one cycle.
//  - Latency from the change to LOAD is 1 cycle. in_column holds its value until the next fetch.
//  - If column_seg changes again before LOAD, the newest index wins. No LOAD is issued for a superseded index.
//  Frame boundary: a change from shadow COLS-1 to column_seg 0, qualified in cycle t.
//  - If swap_pend=1: the front/back select toggles in cycle t.
//  - The column-0 fetch in t+1 reads the new front buffer.
//  - In t+1, IN_CLR=1 for one cycle, coincident with LOAD; swap_pend clears.
//  - Any other change of column_seg (skip, backwards) only fetches; it never swaps.
//  Host writes:
//  - wr_en writes the back buffer in one cycle.
//  - A write in the same cycle as the swap lands in the pre-swap back buffer, so it is visible in the new frame.
//  - Writes never touch the front buffer.
//  - A repeated swap_req while pending is absorbed: one swap only.
//  Clear state machine: IDLE -> CLEAR -> IDLE.
//  - clr_req in IDLE enters CLEAR with busy=1.
//  - One back-buffer address is zeroed per cycle, 0..COLS-1, COLS cycles total. Then return to IDLE and busy=0.
//  - wr_en is ignored while busy.
//  - clr_req while busy is ignored.
//  - A swap due during CLEAR is deferred to the next frame boundary. swap_pend stays 1; display fetches continue.
//  - clr_req and wr_en in the same IDLE cycle: the clear wins and the write is dropped.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous), including a CLEAR in progress.
// TESTING
//  T1 reset, write col3=16'hA5A5 and swap_req, step column_seg 0..15,0..3 -> swap at wrap; LOAD one cycle after each change; in_column=16'hA5A5 at col 3 of frame 2; IN_CLR only at col 0 of frame 2
//  T2 write front-visible? write col5=16'h00FF without swap, sweep frame -> col 5 still shows old data (0)
//  T3 swap_req in same cycle as wrap 15->0 with wr_en col0=16'h8001 -> swap that cycle; column 0 fetch shows 16'h8001
//  T4 fill back with 16'hFFFF, clr_req, wr_en during busy -> busy exactly 16 cycles; after swap every column reads 0
//  T5 column_seg 2->3->4 on consecutive cycles -> single LOAD with in_column=front[4]; assert RESET mid-CLEAR -> all outputs 0, busy 0

Source files
------------

// File: rtl/dot_frame_source.sv
// dot_frame_source: double-buffered 16x16 column source with tear-free swap and background back-buffer clear
module dot_frame_source #(
  parameter int COLS = 16,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          swap_req,
  input  logic          clr_req,
  input  logic [AW-1:0] column_seg,
  output logic [DW-1:0] in_column,
  output logic          LOAD,
  output logic          IN_CLR,
  output logic          swap_pend,
  output logic          busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [DW-1:0] mem [2][COLS];
  logic [AW-1:0] shadow, clr_addr;
  logic front, load_q, change, boundary, swap_now, wr_fire;
  logic [DW-1:0] fetch;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (clr_req ? CLEAR : IDLE)
                               : (clr_addr == AW'(COLS-1) ? IDLE : CLEAR);
  always_comb
    busy = (state == CLEAR);
  // a write to the pre-swap back buffer at the swapped-in column must reach the fetch directly
  always_comb begin
    change   = column_seg != shadow;
    boundary = change && shadow == AW'(COLS-1) && column_seg == '0;
    swap_now = boundary && (swap_pend || swap_req) && state == IDLE;
    wr_fire  = wr_en && !clr_req && state == IDLE;
    fetch    = (swap_now && wr_fire && wr_addr == column_seg) ? wr_data
                                                              : mem[front ^ swap_now][column_seg];
    LOAD     = load_q && !change;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < COLS; j++)
          mem[i][j] <= '0;
      front     <= 1'b0;
      shadow    <= '1;
      load_q    <= 1'b0;
      IN_CLR    <= 1'b0;
      swap_pend <= 1'b0;
      in_column <= '0;
      clr_addr  <= '0;
    end else begin
      shadow    <= column_seg;
      load_q    <= change;
      IN_CLR    <= swap_now;
      swap_pend <= swap_now ? 1'b0 : (swap_pend || swap_req);
      clr_addr  <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
      if (change) in_column <= fetch;
      if (swap_now) front <= !front;
      if (state == CLEAR) mem[!front][clr_addr] <= '0;
      else if (wr_fire) mem[!front][wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_dot_frame_source.sv
// tb_dot_frame_source: table-driven checks of fetch/swap/write plus hand sequences for clear, supersede and reset
module tb_dot_frame_source;
  logic CLK = 0, RESET = 1, wr_en = 0, swap_req = 0, clr_req = 0;
  logic [3:0] wr_addr = 0, column_seg = 0;
  logic [15:0] wr_data = 0, in_column;
  logic LOAD, IN_CLR, swap_pend, busy;
  int pass_n = 0, total_n = 0;

  dot_frame_source dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .clr_req(clr_req), .column_seg(column_seg),
    .in_column(in_column), .LOAD(LOAD), .IN_CLR(IN_CLR), .swap_pend(swap_pend), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] seg; logic we; logic [3:0] wa; logic [15:0] wd; logic sr, cr;
    logic load, inclr, pend, bsy; logic [15:0] col;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] seg, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic sr, input logic cr, input logic load, input logic inclr,
                     input logic pend, input logic bsy, input logic [15:0] col);
    vec_t v;
    v.seg = seg; v.we = we; v.wa = wa; v.wd = wd; v.sr = sr; v.cr = cr;
    v.load = load; v.inclr = inclr; v.pend = pend; v.bsy = bsy; v.col = col;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] seg, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic sr, input logic cr);
    column_seg = seg; wr_en = we; wr_addr = wa; wr_data = wd; swap_req = sr; clr_req = cr;
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int busy_cnt;
    // T1: write col3 + swap request, swap lands at the wrap
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 3, 16'hA5A5, 1, 0, 0, 0, 1, 0, 16'h0000);
    for (int s = 1; s < 16; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000);
    for (int s = 1; s < 4; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 0, 0, s == 3 ? 16'hA5A5 : 16'h0000);
    // T2: back write without swap stays invisible
    add(3, 1, 5, 16'h00FF, 0, 0, 0, 0, 0, 0, 16'hA5A5);
    for (int s = 4; s < 16; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000);
    for (int s = 1; s < 6; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 0, 0, s == 3 ? 16'hA5A5 : 16'h0000);
    // T3: swap_req and write to col0 in the wrap cycle
    for (int s = 6; s < 16; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h8001, 1, 0, 1, 1, 0, 0, 16'h8001);
    for (int s = 1; s < 6; s++) add(4'(s), 0, 0, 0, 0, 0, 1, 0, 0, 0, s == 5 ? 16'h00FF : 16'h0000);

    #12;
    chk("reset_in_column", in_column, 16'h0000);
    chk("reset_LOAD", LOAD, 1'b0);
    chk("reset_IN_CLR", IN_CLR, 1'b0);
    chk("reset_swap_pend", swap_pend, 1'b0);
    chk("reset_busy", busy, 1'b0);
    RESET = 0;

    foreach (vq[k]) begin
      drive(vq[k].seg, vq[k].we, vq[k].wa, vq[k].wd, vq[k].sr, vq[k].cr);
      cyc();
      chk($sformatf("v%0d_LOAD", k), LOAD, vq[k].load);
      chk($sformatf("v%0d_IN_CLR", k), IN_CLR, vq[k].inclr);
      chk($sformatf("v%0d_swap_pend", k), swap_pend, vq[k].pend);
      chk($sformatf("v%0d_busy", k), busy, vq[k].bsy);
      chk($sformatf("v%0d_in_column", k), in_column, vq[k].col);
    end

    // T4: fill back with FFFF, clear with dropped/ignored writes, swap deferred across a wrap
    for (int a = 0; a < 16; a++) begin drive(5, 1, 4'(a), 16'hFFFF, 0, 0); cyc(); end
    busy_cnt = 0;
    for (int c = 0; c < 22; c++) begin
      drive(c == 0 ? 4'd5 : (c <= 10 ? 4'(5 + c) : 4'd0), c <= 15, c == 0 ? 4'd7 : 4'd9,
            c == 0 ? 16'h1234 : 16'h5555, c == 1, c <= 1);
      cyc();
      if (busy) busy_cnt++;
      if (c == 11) begin
        chk("t4_wrap_busy_LOAD", LOAD, 1'b1);
        chk("t4_wrap_busy_IN_CLR", IN_CLR, 1'b0);
        chk("t4_wrap_busy_pend", swap_pend, 1'b1);
        chk("t4_wrap_busy_col", in_column, 16'h8001);
      end
    end
    chk("t4_busy_cycles", 16'(busy_cnt), 16'd16);
    chk("t4_pend_after_clear", swap_pend, 1'b1);
    for (int s = 1; s < 16; s++) begin
      drive(4'(s), 0, 0, 0, 0, 0); cyc();
      chk($sformatf("t4_old_col%0d", s), in_column, s == 5 ? 16'h00FF : 16'h0000);
    end
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("t4_swap_IN_CLR", IN_CLR, 1'b1);
    chk("t4_swap_pend", swap_pend, 1'b0);
    chk("t4_new_col0", in_column, 16'h0000);
    for (int s = 1; s < 16; s++) begin
      drive(4'(s), 0, 0, 0, 0, 0); cyc();
      chk($sformatf("t4_cleared_col%0d", s), in_column, 16'h0000);
    end

    // T5: superseded index and asynchronous reset during a clear
    drive(15, 1, 3, 16'h3333, 0, 0); cyc();
    drive(15, 1, 4, 16'h4444, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("t5_swap_IN_CLR", IN_CLR, 1'b1);
    chk("t5_col0", in_column, 16'h8001);
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(2, 0, 0, 0, 0, 0); cyc();
    drive(3, 0, 0, 0, 0, 0); cyc();
    drive(4, 0, 0, 0, 0, 0); #1;
    chk("t5_superseded_LOAD", LOAD, 1'b0);
    cyc();
    chk("t5_newest_LOAD", LOAD, 1'b1);
    chk("t5_newest_col", in_column, 16'h4444);
    cyc();
    chk("t5_single_LOAD", LOAD, 1'b0);
    chk("t5_hold_col", in_column, 16'h4444);
    drive(4, 0, 0, 0, 1, 1); cyc();
    chk("t5_clear_busy", busy, 1'b1);
    chk("t5_clear_pend", swap_pend, 1'b1);
    drive(4, 0, 0, 0, 0, 0); cyc(); cyc();
    #2 RESET = 1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_pend", swap_pend, 1'b0);
    chk("t5_rst_col", in_column, 16'h0000);
    chk("t5_rst_LOAD", LOAD, 1'b0);
    chk("t5_rst_IN_CLR", IN_CLR, 1'b0);
    cyc();
    RESET = 0;
    cyc();
    chk("t5_post_rst_LOAD", LOAD, 1'b1);
    chk("t5_post_rst_col4", in_column, 16'h0000);
    chk("t5_post_rst_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
